// File: rtl/io_stream_write_array.sv
// io_stream_write_array
// Streams n elements of an external array, read in address order 0..n-1,
// onto sOut. The block signals completion with out_valid/out_ready.
// The array port is read-only: arr_we and arr_di are tied low.
// Optional feature macro IO_STREAM_WRITE_ARRAY_LAST_EN adds the output
// sOut_last, which marks the final element of a request.
`timescale 1ns/1ps

module io_stream_write_array #(
  parameter int intN  = 8,
  parameter int addrN = 8
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  input  logic [intN-1:0]  n,
  output logic [addrN-1:0] arr_addr,
  output logic             arr_we,
  output logic [intN-1:0]  arr_di,
  input  logic [intN-1:0]  arr_do,
  output logic             arr_valid,
  input  logic             arr_ready,
  output logic [intN-1:0]  sOut,
  output logic             sOut_valid,
  input  logic             sOut_ready
`ifdef IO_STREAM_WRITE_ARRAY_LAST_EN
  ,
  output logic             sOut_last
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    SEND = 2'd2,
    DONE = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [intN-1:0] idx_q, idx_d;
  logic [intN-1:0] count_q, count_d;
  logic [intN-1:0] data_q, data_d;
  // Keeps in_ready low while reset is asserted and releases it on the
  // first clock after reset is removed, even though the state is already IDLE.
  logic            armed_q;
  logic [intN-1:0] idx_inc;

  // idx wraps at intN bits; only its low addrN bits reach the address port.
  assign idx_inc = idx_q + intN'(1);

  // State and datapath registers, asynchronously cleared.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      count_q <= '0;
      data_q  <= '0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      count_q <= count_d;
      data_q  <= data_d;
      armed_q <= 1'b1;
    end
  end

  // Next-state logic and per-state handshake outputs.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    count_d    = count_q;
    data_d     = data_q;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    arr_valid  = 1'b0;
    arr_addr   = '0;
    sOut_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = armed_q;
        if (armed_q && in_valid) begin
          count_d = n;
          idx_d   = '0;
          state_d = (n != '0) ? READ : DONE;
        end
      end
      READ: begin
        arr_valid = 1'b1;
        arr_addr  = idx_q[addrN-1:0];
        if (arr_ready) begin
          data_d  = arr_do;
          state_d = SEND;
        end
      end
      SEND: begin
        sOut_valid = 1'b1;
        if (sOut_ready) begin
          idx_d   = idx_inc;
          state_d = (idx_inc == count_q) ? DONE : READ;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // sOut presents the captured element; it only changes on a new array read.
  assign sOut   = data_q;
  assign arr_we = 1'b0;
  assign arr_di = '0;

`ifdef IO_STREAM_WRITE_ARRAY_LAST_EN
  // The element being sent is the last one when the incremented index reaches count.
  assign sOut_last = (state_q == SEND) && (idx_inc == count_q);
`endif

endmodule

// File: tb/tb_io_stream_write_array.sv
// Directed bench for io_stream_write_array.
// u_dut uses the default widths; u_dut2 uses addrN=2 to exercise address wrap.
`timescale 1ns/1ps

module tb_io_stream_write_array;
  localparam int W = 8;

  logic clk = 1'b0;
  logic nrst = 1'b1;
  always #5 clk = ~clk;

  // main instance
  logic         in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0] n;
  logic [7:0]   arr_addr;
  logic         arr_we;
  logic [W-1:0] arr_di;
  logic [W-1:0] arr_do = '0;
  logic         arr_valid;
  logic         arr_ready = 1'b0;
  logic [W-1:0] sOut;
  logic         sOut_valid;
  logic         sOut_ready = 1'b1;
`ifdef IO_STREAM_WRITE_ARRAY_LAST_EN
  logic         sOut_last;
  logic         sOut_last2;
`endif

  // narrow-address instance
  logic         in_valid2, in_ready2, out_valid2, out_ready2;
  logic [W-1:0] n2;
  logic [1:0]   arr_addr2;
  logic         arr_we2;
  logic [W-1:0] arr_di2;
  logic [W-1:0] arr_do2 = '0;
  logic         arr_valid2;
  logic         arr_ready2 = 1'b0;
  logic [W-1:0] sOut2;
  logic         sOut_valid2;

  io_stream_write_array #(.intN(W), .addrN(8)) u_dut (
    .clk(clk), .nrst(nrst),
    .in_valid(in_valid), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready),
    .n(n),
    .arr_addr(arr_addr), .arr_we(arr_we), .arr_di(arr_di), .arr_do(arr_do),
    .arr_valid(arr_valid), .arr_ready(arr_ready),
    .sOut(sOut), .sOut_valid(sOut_valid), .sOut_ready(sOut_ready)
`ifdef IO_STREAM_WRITE_ARRAY_LAST_EN
    , .sOut_last(sOut_last)
`endif
  );

  io_stream_write_array #(.intN(W), .addrN(2)) u_dut2 (
    .clk(clk), .nrst(nrst),
    .in_valid(in_valid2), .in_ready(in_ready2),
    .out_valid(out_valid2), .out_ready(out_ready2),
    .n(n2),
    .arr_addr(arr_addr2), .arr_we(arr_we2), .arr_di(arr_di2), .arr_do(arr_do2),
    .arr_valid(arr_valid2), .arr_ready(arr_ready2),
    .sOut(sOut2), .sOut_valid(sOut_valid2), .sOut_ready(sOut_ready)
`ifdef IO_STREAM_WRITE_ARRAY_LAST_EN
    , .sOut_last(sOut_last2)
`endif
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // array models
  logic [W-1:0] mem  [0:255];
  logic [W-1:0] mem2 [0:3];
  int rd_lat = 0;
  int rd_cnt = 0;

  // array responder for u_dut: answers after rd_lat waiting cycles
  always @(posedge clk) begin
    #1;
    if (arr_valid) begin
      if (rd_cnt >= rd_lat) begin
        arr_ready = 1'b1;
        arr_do    = mem[arr_addr];
        rd_cnt    = 0;
      end else begin
        arr_ready = 1'b0;
        rd_cnt++;
      end
    end else begin
      arr_ready = 1'b0;
      rd_cnt    = 0;
    end
  end

  // array responder for u_dut2: zero wait
  always @(posedge clk) begin
    #1;
    arr_ready2 = arr_valid2;
    arr_do2    = mem2[arr_addr2];
  end

  // downstream ready: constant 1 or toggling each cycle
  int sr_mode = 0;
  always @(posedge clk) begin
    #1;
    if (sr_mode == 1) sOut_ready = ~sOut_ready;
    else              sOut_ready = 1'b1;
  end

  // observed streams
  logic [W-1:0] q_data[$];
  logic [7:0]   q_addr[$];
  logic         q_last[$];
  logic [W-1:0] q2[$];
  logic         ql2[$];
  int           arv_cnt = 0;
  logic         prev_stall = 1'b0;
  logic [W-1:0] prev_sout = '0;

  always @(negedge clk) begin
    if (arr_valid) arv_cnt++;
    if (arr_valid && arr_ready) q_addr.push_back(arr_addr);
    if (prev_stall) begin
      check("stall_valid", {31'd0, sOut_valid}, 32'd1);
      check("stall_data", {24'd0, sOut}, {24'd0, prev_sout});
    end
    if (sOut_valid && sOut_ready) begin
      q_data.push_back(sOut);
`ifdef IO_STREAM_WRITE_ARRAY_LAST_EN
      q_last.push_back(sOut_last);
`endif
    end
    prev_stall = sOut_valid && !sOut_ready;
    prev_sout  = sOut;
    if (sOut_valid2 && sOut_ready) begin
      q2.push_back(sOut2);
`ifdef IO_STREAM_WRITE_ARRAY_LAST_EN
      ql2.push_back(sOut_last2);
`endif
    end
  end

  task automatic run_req(input logic [W-1:0] nn, input int max_cyc, output int cyc);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("in_ready_wait", {31'd0, in_ready}, 32'd1);
    n = nn;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    cyc = 0;
    while (!out_valid && cyc < max_cyc) begin
      @(negedge clk);
      cyc++;
    end
    check("out_valid_seen", {31'd0, out_valid}, 32'd1);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("back_idle", {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, s, a, av, g, ov;
    in_valid = 1'b0; out_ready = 1'b0; n = '0;
    in_valid2 = 1'b0; out_ready2 = 1'b0; n2 = '0;
    for (int i = 0; i < 256; i++) mem[i] = W'(i);
    for (int i = 0; i < 4; i++) mem2[i] = W'(10 + i);

    // reset values
    #1 nrst = 1'b0;
    #2;
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_sOut_valid", {31'd0, sOut_valid}, 32'd0);
    check("rst_arr_valid", {31'd0, arr_valid}, 32'd0);
    check("rst_arr_addr", {24'd0, arr_addr}, 32'd0);
    check("rst_arr_we", {31'd0, arr_we}, 32'd0);
    check("rst_arr_di", {24'd0, arr_di}, 32'd0);
    check("rst_sOut", {24'd0, sOut}, 32'd0);
    check("rst_in_ready2", {31'd0, in_ready2}, 32'd0);
    check("rst_arr_we2", {31'd0, arr_we2}, 32'd0);
    check("rst_arr_di2", {24'd0, arr_di2}, 32'd0);
`ifdef IO_STREAM_WRITE_ARRAY_LAST_EN
    check("rst_sOut_last", {31'd0, sOut_last}, 32'd0);
`endif
    @(negedge clk);
    nrst = 1'b1;
    #1;
    check("in_ready_pre_clk", {31'd0, in_ready}, 32'd0);
    @(posedge clk);
    #1;
    check("in_ready_post_clk", {31'd0, in_ready}, 32'd1);

    // n=16, full throughput
    s = q_data.size(); a = q_addr.size();
    run_req(8'd16, 100, cyc);
    check("t16_count", q_data.size() - s, 32'd16);
    check("t16_addr_count", q_addr.size() - a, 32'd16);
    for (int i = 0; i < 16; i++) begin
      check("t16_data", {24'd0, q_data[s + i]}, i);
      check("t16_addr", {24'd0, q_addr[a + i]}, i);
    end
    check("t16_cycles", cyc, 32'd32);

    // n=0
    s = q_data.size(); av = arv_cnt;
    run_req(8'd0, 10, cyc);
    check("n0_cycles", cyc, 32'd0);
    check("n0_no_sout", q_data.size() - s, 32'd0);
    check("n0_no_arr_valid", arv_cnt - av, 32'd0);

    // n=4 with slow array and toggling sOut_ready
    for (int i = 0; i < 4; i++) mem[i] = W'(8'hA0 + i);
    rd_lat = 3; sr_mode = 1;
    s = q_data.size(); a = q_addr.size();
    run_req(8'd4, 300, cyc);
    sr_mode = 0; rd_lat = 0;
    check("bp_count", q_data.size() - s, 32'd4);
    check("bp_addr_count", q_addr.size() - a, 32'd4);
    for (int i = 0; i < 4; i++) begin
      check("bp_data", {24'd0, q_data[s + i]}, 32'hA0 + i);
      check("bp_addr", {24'd0, q_addr[a + i]}, i);
    end
    for (int i = 0; i < 4; i++) mem[i] = W'(i);

    // reset in the middle of n=8
    @(negedge clk);
    g = 0;
    while (!in_ready && g < 50) begin
      @(negedge clk);
      g++;
    end
    s = q_data.size();
    n = 8'd8; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    #2;
    g = 0;
    while ((q_data.size() - s) < 2 && g < 100) begin
      @(negedge clk);
      #2;
      g++;
    end
    check("mid_two_elems", q_data.size() - s, 32'd2);
    nrst = 1'b0;
    #0.5;
    check("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_sOut_valid", {31'd0, sOut_valid}, 32'd0);
    check("mid_rst_arr_valid", {31'd0, arr_valid}, 32'd0);
    check("mid_rst_arr_addr", {24'd0, arr_addr}, 32'd0);
    #0.5;
    nrst = 1'b1;
    ov = 0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid) ov++;
    end
    check("mid_no_out_valid", ov, 32'd0);
    s = q_data.size(); a = q_addr.size();
    run_req(8'd2, 50, cyc);
    check("post_rst_count", q_data.size() - s, 32'd2);
    for (int i = 0; i < 2; i++) begin
      check("post_rst_data", {24'd0, q_data[s + i]}, i);
      check("post_rst_addr", {24'd0, q_addr[a + i]}, i);
    end

`ifdef IO_STREAM_WRITE_ARRAY_LAST_EN
    // last flag on n=3
    s = q_last.size();
    run_req(8'd3, 50, cyc);
    check("last_count", q_last.size() - s, 32'd3);
    check("last_0", {31'd0, q_last[s]}, 32'd0);
    check("last_1", {31'd0, q_last[s + 1]}, 32'd0);
    check("last_2", {31'd0, q_last[s + 2]}, 32'd1);
`endif

    // addrN=2 wrap, n=6
    s = q2.size();
    @(negedge clk);
    g = 0;
    while (!in_ready2 && g < 50) begin
      @(negedge clk);
      g++;
    end
    check("w_in_ready", {31'd0, in_ready2}, 32'd1);
    n2 = 8'd6; in_valid2 = 1'b1;
    @(negedge clk);
    in_valid2 = 1'b0;
    g = 0;
    while (!out_valid2 && g < 100) begin
      @(negedge clk);
      g++;
    end
    check("w_out_valid", {31'd0, out_valid2}, 32'd1);
    out_ready2 = 1'b1;
    @(negedge clk);
    out_ready2 = 1'b0;
    check("w_count", q2.size() - s, 32'd6);
    for (int i = 0; i < 6; i++) begin
      check("w_data", {24'd0, q2[s + i]}, 32'd10 + (i % 4));
    end
`ifdef IO_STREAM_WRITE_ARRAY_LAST_EN
    for (int i = 0; i < 6; i++) begin
      check("w_last", {31'd0, ql2[s + i]}, (i == 5) ? 32'd1 : 32'd0);
    end
`endif

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
